// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker control sequencer: opcodes, instruction
// classes, sequencer states and class-property helpers.
package tinker_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_2000;
    localparam logic [63:0] PC_STEP          = 64'h0000_0000_0000_0004;

    localparam logic [4:0] OP_BR0   = 5'h08;
    localparam logic [4:0] OP_BR1   = 5'h09;
    localparam logic [4:0] OP_BR2   = 5'h0A;
    localparam logic [4:0] OP_BR3   = 5'h0B;
    localparam logic [4:0] OP_CALL  = 5'h0C;
    localparam logic [4:0] OP_RET   = 5'h0D;
    localparam logic [4:0] OP_BR4   = 5'h0E;
    localparam logic [4:0] OP_PRIV  = 5'h0F;
    localparam logic [4:0] OP_LOAD  = 5'h10;
    localparam logic [4:0] OP_STORE = 5'h13;
    localparam logic [4:0] OP_ILL0  = 5'h1E;
    localparam logic [4:0] OP_ILL1  = 5'h1F;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_RET     = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_CALL    = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    function automatic logic cls_is_mem(input op_class_e cls);
        logic r;
        case (cls)
            CLS_LOAD, CLS_RET, CLS_STORE, CLS_CALL: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic cls_is_store(input op_class_e cls);
        logic r;
        case (cls)
            CLS_STORE, CLS_CALL: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic cls_is_stop(input op_class_e cls);
        logic r;
        case (cls)
            CLS_HALT, CLS_ILLEGAL: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinker_op_class.sv
// Combinational opcode classifier: maps opcode plus literal field to an
// instruction class and a flag saying whether the class writes rd.
module tinker_op_class
    import tinker_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [11:0] lit,
    output logic [2:0]  op_class,
    output logic        writes_rd
);

    op_class_e cls_s;

    // Opcode to class; everything not listed explicitly is an ALU operation.
    always_comb begin
        cls_s = CLS_ALU;
        case (opcode)
            OP_BR0, OP_BR1, OP_BR2, OP_BR3, OP_BR4: cls_s = CLS_BRANCH;
            OP_CALL:                                cls_s = CLS_CALL;
            OP_RET:                                 cls_s = CLS_RET;
            OP_LOAD:                                cls_s = CLS_LOAD;
            OP_STORE:                               cls_s = CLS_STORE;
            OP_PRIV: begin
                // Only the zero-literal form of the privileged opcode is a halt
                if (lit == 12'h000) begin
                    cls_s = CLS_HALT;
                end else begin
                    cls_s = CLS_ILLEGAL;
                end
            end
            OP_ILL0, OP_ILL1:                       cls_s = CLS_ILLEGAL;
            default:                                cls_s = CLS_ALU;
        endcase
    end

    // Register-file write permission per class.
    always_comb begin
        writes_rd = 1'b0;
        case (cls_s)
            CLS_ALU, CLS_LOAD: writes_rd = 1'b1;
            default:           writes_rd = 1'b0;
        endcase
    end

    assign op_class = cls_s;

endmodule

// File: rtl/tinker_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the Tinker
// core; owns the PC, the instruction register and all datapath strobes.
module tinker_ctrl
    import tinker_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] pc,
    output logic        halted,
    output logic        illegal
);

    state_e      state_r;
    op_class_e   class_r;
    logic        wr_rd_r;
    logic [63:0] pc_r;
    logic [31:0] instr_r;
    logic        imem_req_r;
    logic        alu_en_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic        rf_we_r;
    logic        halted_r;
    logic        illegal_r;

    logic [2:0]  dec_class_s;
    logic        dec_wr_s;
    op_class_e   dec_cls_s;

    tinker_op_class u_op_class (
        .opcode    (instr_r[31:27]),
        .lit       (instr_r[11:0]),
        .op_class  (dec_class_s),
        .writes_rd (dec_wr_s)
    );

    assign dec_cls_s = op_class_e'(dec_class_s);

    // Sequencer: outputs are registered and set on entry to the state that
    // owns them, so each strobe is a clean Moore output of the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            class_r    <= CLS_ALU;
            wr_rd_r    <= 1'b0;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            imem_req_r <= 1'b0;
            alu_en_r   <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            rf_we_r    <= 1'b0;
            halted_r   <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_req_r && imem_ack) begin
                        instr_r    <= imem_rdata;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    class_r <= dec_cls_s;
                    wr_rd_r <= dec_wr_s;
                    if (cls_is_stop(dec_cls_s)) begin
                        state_r   <= ST_HALT;
                        halted_r  <= 1'b1;
                        illegal_r <= (dec_cls_s == CLS_ILLEGAL);
                    end else begin
                        state_r  <= ST_EXEC;
                        alu_en_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    alu_en_r <= 1'b0;
                    if (cls_is_mem(class_r)) begin
                        state_r    <= ST_MEM;
                        dmem_req_r <= 1'b1;
                        dmem_we_r  <= cls_is_store(class_r);
                    end else begin
                        state_r <= ST_WB;
                        rf_we_r <= wr_rd_r;
                    end
                end
                ST_MEM: begin
                    if (dmem_req_r && dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        state_r    <= ST_WB;
                        rf_we_r    <= wr_rd_r;
                    end else begin
                        dmem_req_r <= 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we_r    <= 1'b0;
                    // PC arithmetic wraps naturally at 64 bits
                    pc_r       <= br_taken ? br_target : (pc_r + PC_STEP);
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b1;
                end
                ST_HALT: begin
                    imem_req_r <= 1'b0;
                    alu_en_r   <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                    rf_we_r    <= 1'b0;
                    halted_r   <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    imem_req_r <= 1'b0;
                    alu_en_r   <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                    rf_we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign instr     = instr_r;
    assign alu_en    = alu_en_r;
    assign dmem_req  = dmem_req_r;
    assign dmem_we   = dmem_we_r;
    assign rf_we     = rf_we_r;
    assign pc        = pc_r;
    assign halted    = halted_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_tinker_ctrl.sv
// Directed self-checking bench for tinker_ctrl; cycle 1 is the first FETCH
// cycle after reset release, outputs sampled on the falling edge.
module tb_tinker_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = 64'h0;
    logic [63:0] pc;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tinker_ctrl #(.RESET_PC(64'h2000)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    task automatic do_reset();
        reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; br_target = 64'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pc !== 64'h2000) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 64'h2000); end
        checks++; if (imem_addr !== 64'h2000) begin errors++; $display("FAIL reset_imem_addr: got %h exp %h", imem_addr, 64'h2000); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
        checks++; if ({imem_req, alu_en, dmem_req, dmem_we, rf_we, halted, illegal} !== 7'b0)
            begin errors++; $display("FAIL reset_strobes: got %b exp 0000000", {imem_req, alu_en, dmem_req, dmem_we, rf_we, halted, illegal}); end
        reset_n = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b exp 0", imem_req); end
    endtask

    task automatic test_alu();
        do_reset(); imem_ack = 1'b1; imem_rdata = 32'hC022_3000;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            checks++; if (alu_en !== (cyc == 3)) begin errors++; $display("FAIL alu_en_c%0d: got %b exp %b", cyc, alu_en, cyc == 3); end
            checks++; if (rf_we !== (cyc == 4)) begin errors++; $display("FAIL alu_rf_we_c%0d: got %b exp %b", cyc, rf_we, cyc == 4); end
            checks++; if (imem_req !== (cyc == 1 || cyc == 5)) begin errors++; $display("FAIL alu_imem_req_c%0d: got %b exp %b", cyc, imem_req, cyc == 1 || cyc == 5); end
        end
        checks++; if (pc !== 64'h2004) begin errors++; $display("FAIL alu_pc: got %h exp %h", pc, 64'h2004); end
        checks++; if (imem_addr !== 64'h2004) begin errors++; $display("FAIL alu_next_addr: got %h exp %h", imem_addr, 64'h2004); end
        checks++; if (instr !== 32'hC022_3000) begin errors++; $display("FAIL alu_instr: got %h exp %h", instr, 32'hC022_3000); end
    endtask

    task automatic test_fetch_wait();
        int req_cnt = 0;
        int wb_cyc = 0;
        do_reset(); imem_rdata = 32'hC842_003F;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
            if (rf_we) wb_cyc = cyc;
            imem_ack = (cyc == 4);
            if (cyc >= 5) imem_rdata = 32'hDEAD_BEEF;
        end
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL wait_req_cycles: got %0d exp 4", req_cnt); end
        checks++; if (wb_cyc != 7) begin errors++; $display("FAIL wait_total_cycles: got %0d exp 7", wb_cyc); end
        @(negedge clk);
        checks++; if (instr !== 32'hC842_003F) begin errors++; $display("FAIL wait_instr_stable: got %h exp %h", instr, 32'hC842_003F); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h2004) begin errors++; $display("FAIL wait_refetch: got req %b addr %h exp 1 %h", imem_req, imem_addr, 64'h2004); end
    endtask

    task automatic test_load();
        int req_cnt = 0;
        int we_cnt = 0;
        int wb_cyc = 0;
        do_reset(); imem_ack = 1'b1; imem_rdata = 32'h8000_0000;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (dmem_req) req_cnt++;
            if (dmem_we) we_cnt++;
            if (rf_we) wb_cyc = cyc;
            dmem_ack = (cyc == 6);
        end
        checks++; if (req_cnt != 3) begin errors++; $display("FAIL load_dmem_req_cycles: got %0d exp 3", req_cnt); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL load_dmem_we: got %0d exp 0", we_cnt); end
        checks++; if (wb_cyc != 7) begin errors++; $display("FAIL load_rf_we_cycle: got %0d exp 7", wb_cyc); end
        @(negedge clk);
        checks++; if (pc !== 64'h2004) begin errors++; $display("FAIL load_pc: got %h exp %h", pc, 64'h2004); end
    endtask

    task automatic test_store_call_ret();
        logic [31:0] ops [3];
        logic        exp_we [3];
        ops[0] = 32'h9800_0000; exp_we[0] = 1'b1;
        ops[1] = 32'h6000_0000; exp_we[1] = 1'b1;
        ops[2] = 32'h6800_0000; exp_we[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int req_cnt = 0;
            int we_cnt = 0;
            int rf_cnt = 0;
            do_reset(); imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = ops[k];
            for (int cyc = 1; cyc <= 5; cyc++) begin
                @(negedge clk);
                if (dmem_req) req_cnt++;
                if (dmem_we) we_cnt++;
                if (rf_we) rf_cnt++;
            end
            checks++; if (req_cnt != 1) begin errors++; $display("FAIL mem%0d_req_cycles: got %0d exp 1", k, req_cnt); end
            checks++; if (we_cnt != int'(exp_we[k])) begin errors++; $display("FAIL mem%0d_we: got %0d exp %0d", k, we_cnt, exp_we[k]); end
            checks++; if (rf_cnt != 0) begin errors++; $display("FAIL mem%0d_no_rf_we: got %0d exp 0", k, rf_cnt); end
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h2004) begin errors++; $display("FAIL mem%0d_5cyc: got req %b addr %h exp 1 %h", k, imem_req, imem_addr, 64'h2004); end
        end
    endtask

    task automatic test_branch();
        int rf_cnt = 0;
        do_reset(); imem_ack = 1'b1; imem_rdata = 32'h4000_0000;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk);
            if (rf_we) rf_cnt++;
            if (cyc == 5) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h3000) begin errors++; $display("FAIL br_taken_addr: got req %b addr %h exp 1 %h", imem_req, imem_addr, 64'h3000); end
            end
            if (cyc == 9) begin
                checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL br_high_addr: got %h exp %h", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC); end
            end
            if (cyc == 13) begin
                checks++; if (pc !== 64'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL br_pc_wrap: got pc %h req %b exp 0 1", pc, imem_req); end
            end
            br_taken  = (cyc == 4 || cyc == 8);
            br_target = (cyc == 4) ? 64'h3000 : (cyc == 8) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h5555;
        end
        checks++; if (rf_cnt != 0) begin errors++; $display("FAIL br_no_rf_we: got %0d exp 0", rf_cnt); end
        br_taken = 1'b0;
    endtask

    task automatic test_halt_illegal();
        logic [31:0] ops [4];
        logic        exp_ill [4];
        ops[0] = 32'h7800_0000; exp_ill[0] = 1'b0;
        ops[1] = 32'hF800_0000; exp_ill[1] = 1'b1;
        ops[2] = 32'h7800_0001; exp_ill[2] = 1'b1;
        ops[3] = 32'hF000_0000; exp_ill[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int req_cnt = 0;
            int alu_cnt = 0;
            do_reset(); imem_ack = 1'b1; imem_rdata = ops[k];
            for (int cyc = 1; cyc <= 12; cyc++) begin
                @(negedge clk);
                if (cyc >= 3 && imem_req) req_cnt++;
                if (alu_en) alu_cnt++;
                if (cyc == 2) begin
                    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt%0d_early: got %b exp 0", k, halted); end
                end
                if (cyc == 3) begin
                    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt%0d_halted: got %b exp 1", k, halted); end
                    checks++; if (illegal !== exp_ill[k]) begin errors++; $display("FAIL halt%0d_illegal: got %b exp %b", k, illegal, exp_ill[k]); end
                end
            end
            checks++; if (req_cnt != 0 || alu_cnt != 0) begin errors++; $display("FAIL halt%0d_quiet: got req %0d alu %0d exp 0 0", k, req_cnt, alu_cnt); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt%0d_absorbing: got %b exp 1", k, halted); end
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset(); imem_ack = 1'b1; imem_rdata = 32'hC022_3000;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 4) imem_rdata = 32'h8000_0000;
        end
        checks++; if (dmem_req !== 1'b1 || pc !== 64'h2004) begin errors++; $display("FAIL rst_mem_setup: got req %b pc %h exp 1 %h", dmem_req, pc, 64'h2004); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_async_dmem_req: got %b exp 0", dmem_req); end
        checks++; if (pc !== 64'h2000 || instr !== 32'h0) begin errors++; $display("FAIL rst_async_state: got pc %h instr %h exp %h 0", pc, instr, 64'h2000); end
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_restart_idle: got %b exp 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin errors++; $display("FAIL rst_restart_fetch: got req %b addr %h exp 1 %h", imem_req, imem_addr, 64'h2000); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fetch_wait();
        test_load();
        test_store_call_ret();
        test_branch();
        test_halt_illegal();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinker_ctrl.md
# tinker_ctrl

Multi-cycle control sequencer for the Tinker core. Fetches 32-bit instructions over a req/ack instruction-memory port, decodes the 5-bit opcode into an instruction class, and sequences ALU execute, data-memory access, register writeback and PC update. It sits between the instruction/data memories and the combinational `tinker_core` datapath, which it drives through the latched instruction word and enable strobes.

## Interface
Parameters:
- `RESET_PC`, 64'h2000: PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction fetch request, held until acknowledged.
- `imem_addr`  out  64  fetch address; always equals `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  latched instruction register, feeds datapath.
- `alu_en`  out  1  one-cycle execute strobe.
- `dmem_req`  out  1  data access request, held until acknowledged.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req` = 1.
- `dmem_ack`  in  1  data access complete.
- `rf_we`  out  1  one-cycle register-file write strobe for `instr[26:22]`.
- `br_taken`  in  1  from datapath; sampled in WB.
- `br_target`  in  64  from datapath; sampled in WB.
- `pc`  out  64  current program counter.
- `halted`  out  1  core stopped (priv halt or illegal).
- `illegal`  out  1  halt caused by an illegal opcode.

## Operation
- Opcode = `instr[31:27]`. Classes:
  - ALU (writes rd): 0x00–0x07, 0x10 excluded, 0x11, 0x12, 0x14–0x1D.
  - LOAD (writes rd): 0x10. RET (load, no rd write): 0x0D.
  - STORE: 0x13. CALL (store, no rd write): 0x0C.
  - BRANCH (no write): 0x08–0x0B, 0x0E.
  - HALT: 0x0F with `instr[11:0]` = 0. ILLEGAL: 0x0F with nonzero L, 0x1E, 0x1F.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE → FETCH unconditionally.
  - FETCH: `imem_req` = 1. On `imem_ack`: `instr` ← `imem_rdata`, → DECODE; else stay.
  - DECODE → HALT if class is HALT/ILLEGAL (set `illegal` for ILLEGAL), else → EXEC.
  - EXEC: `alu_en` = 1. LOAD/RET/STORE/CALL → MEM; others → WB.
  - MEM: `dmem_req` = 1, `dmem_we` = 1 for STORE/CALL. On `dmem_ack` → WB.
  - WB: `rf_we` = 1 for ALU and LOAD only. `pc` ← `br_taken ? br_target : pc + 4`, wrapping mod 2^64. → FETCH.
  - HALT: absorbing; all strobes 0; only reset exits.
- `imem_req`, `alu_en`, `dmem_req`, `dmem_we` and `rf_we` are Moore outputs decoded from state and the latched class.

## Timing
- Reset values: state IDLE, `pc` = RESET_PC, `instr` = 0. All strobes, `halted` and `illegal` are 0.
- Asserting reset mid-handshake drops `imem_req`/`dmem_req` immediately. The in-flight transfer is abandoned.
- Acks are sampled only while the matching request is high. An ack in the same cycle the request first rises is accepted; there is no wait state.
- Latency with zero-wait acks, FETCH through WB inclusive:
  - ALU/BRANCH: 4 cycles.
  - LOAD/STORE/CALL/RET: 5 cycles.
  - Each ack wait cycle adds 1.
- `br_taken`/`br_target` need only be valid in the WB cycle.
- `instr` is stable from DECODE until the next FETCH ack.

## Structure
- `tinker_pkg`: opcode localparams, class enum, state enum, RESET_PC default.
- Sub-module `tinker_op_class`: combinational opcode + L → class and writes-rd flag. The FSM, `pc` and `instr` registers live in `tinker_ctrl`.

## Test plan
- Reset release, `imem_ack` tied 1, ADD (0xC0223000) at 0x2000 → `alu_en` in cycle 3, `rf_we` in cycle 4; `pc` = 0x2004; next fetch addr 0x2004.
- ADDI with `imem_ack` delayed 3 cycles → `imem_req` held 4 cycles; `instr` = 0xC842003F; total 7 cycles.
- Load 0x10 with `dmem_ack` delayed 2 → `dmem_req` 3 cycles, `dmem_we` = 0, `rf_we` after; store 0x13 → `dmem_we` = 1 and no `rf_we`.
- Branch 0x08 with `br_taken` = 1, `br_target` = 0x3000 → next `imem_addr` = 0x3000. With `pc` = 0xFFFF_FFFF_FFFF_FFFC and not taken → `pc` wraps to 0.
- priv 0x78000000 → `halted` = 1, `illegal` = 0, no further `imem_req`. Opcode 0x1F → `halted` = 1, `illegal` = 1.
- `reset_n` low during MEM wait → `dmem_req` falls without a clock edge. After release, `pc` = 0x2000 and the sequence restarts at IDLE.
